// File: rtl/ctrl_bm_gen.sv
// rtl/ctrl_bm_gen.sv - bin-manager phase sequencer with watchdog, iteration limit, abort and statistics
//
// Purpose: sequences read-info, load, core, find-backtrack-level, backtrack-across-bin
// and update phases. Each phase start is a one-cycle registered pulse, and each phase
// ends on its done handshake. A run ends in DONE with exactly one of sat/unsat/abort set.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   start_bm_i                   start a run (accepted in IDLE or DONE)
//   abort_i                      user abort (ignored in IDLE and DONE)
//   timeout_cfg_i                per-phase cycle limit, 0 disables the watchdog
//   max_iter_i                   core-run limit checked on LOAD entry, 0 disables it
//   done_bm_o                    high while in DONE
//   global_sat/unsat/abort_o     sticky run result
//   err_code_o, err_phase_o      error cause and the phase that timed out
//   cur_bin_num_o, request_bin_num_o, cur_lvl_o   current bin / level
//   iter_cnt_o, bkt_cnt_o        saturating core-run and cross-bin backtrack counts
//   start_*_o / done_*_i         sub-block handshakes plus their data
module ctrl_bm_gen #(
  parameter int WIDTH_BIN_ID  = 10,
  parameter int WIDTH_CLAUSES = 16,
  parameter int WIDTH_LVL     = 16,
  parameter int WIDTH_TMO     = 16,
  parameter int WIDTH_ITER    = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_bm_i,
  input  logic                     abort_i,
  input  logic [WIDTH_TMO-1:0]     timeout_cfg_i,
  input  logic [WIDTH_ITER-1:0]    max_iter_i,
  output logic                     done_bm_o,
  output logic                     global_sat_o,
  output logic                     global_unsat_o,
  output logic                     global_abort_o,
  output logic [1:0]               err_code_o,
  output logic [2:0]               err_phase_o,
  output logic [WIDTH_BIN_ID-1:0]  cur_bin_num_o,
  output logic [WIDTH_BIN_ID-1:0]  request_bin_num_o,
  output logic [WIDTH_LVL-1:0]     cur_lvl_o,
  output logic [WIDTH_ITER-1:0]    iter_cnt_o,
  output logic [WIDTH_ITER-1:0]    bkt_cnt_o,
  output logic                     start_rdinfo_o,
  input  logic                     done_rdinfo_i,
  input  logic [WIDTH_CLAUSES-1:0] nb_all_i,
  output logic                     start_load_o,
  input  logic                     done_load_i,
  output logic                     start_core_o,
  input  logic                     done_core_i,
  input  logic                     local_sat_i,
  input  logic [WIDTH_LVL-1:0]     cur_lvl_from_core_i,
  output logic                     start_find_o,
  input  logic                     done_find_i,
  input  logic [WIDTH_LVL-1:0]     bkt_lvl_from_find_i,
  input  logic [WIDTH_BIN_ID-1:0]  bkt_bin_from_find_i,
  output logic                     start_bkt_o,
  input  logic                     done_bkt_i,
  output logic                     start_update_o,
  input  logic                     done_update_i
);

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_RD_BIN_INFO    = 3'd1,
    S_LOAD_BIN       = 3'd2,
    S_RUN_CORE       = 3'd3,
    S_FIND_BKT_LVL   = 3'd4,
    S_BKT_ACROSS_BIN = 3'd5,
    S_UPDATE_BIN     = 3'd6,
    S_DONE           = 3'd7
  } state_t;

  localparam logic [WIDTH_BIN_ID-1:0] BIN_ONE  = {{(WIDTH_BIN_ID-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_ITER-1:0]   ITER_ONE = {{(WIDTH_ITER-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_TMO-1:0]    TMO_ONE  = {{(WIDTH_TMO-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic                     sat_q, sat_d, unsat_q, unsat_d, abt_q, abt_d;
  logic [1:0]               err_code_q, err_code_d;
  logic [2:0]               err_phase_q, err_phase_d;
  logic [WIDTH_BIN_ID-1:0]  cur_bin_q, cur_bin_d;
  logic [WIDTH_CLAUSES-1:0] nb_all_q, nb_all_d;
  logic [WIDTH_LVL-1:0]     cur_lvl_q, cur_lvl_d;
  logic [WIDTH_ITER-1:0]    iter_q, iter_d, bkt_q, bkt_d;
  logic [WIDTH_TMO-1:0]     wd_q, wd_d;
  logic                     from_core_q, from_core_d;
  logic                     armed_q, armed_d;
  // start_q[i] is the start pulse of state i+1 (RD_BIN_INFO .. UPDATE_BIN)
  logic [5:0]               start_q, start_d;

  logic                     in_phase, done_sel, done_ok, tmo_hit, load_blocked, bin_is_last, enter;
  logic [WIDTH_ITER-1:0]    iter_inc, bkt_inc;

  assign in_phase     = (state_q != S_IDLE) && (state_q != S_DONE);
  // armed_q goes high the cycle after the phase pulse, so dones during the
  // pulse cycle or before it are dropped.
  assign done_ok      = armed_q && done_sel;
  assign tmo_hit      = (timeout_cfg_i != '0) && (wd_q >= timeout_cfg_i);
  assign load_blocked = (max_iter_i != '0) && (iter_q >= max_iter_i);
  assign bin_is_last  = ({{WIDTH_CLAUSES{1'b0}}, cur_bin_q} == {{WIDTH_BIN_ID{1'b0}}, nb_all_q});
  assign iter_inc     = (&iter_q) ? iter_q : iter_q + ITER_ONE;
  assign bkt_inc      = (&bkt_q) ? bkt_q : bkt_q + ITER_ONE;

  always_comb begin
    done_sel = 1'b0;
    case (state_q)
      S_RD_BIN_INFO:    done_sel = done_rdinfo_i;
      S_LOAD_BIN:       done_sel = done_load_i;
      S_RUN_CORE:       done_sel = done_core_i;
      S_FIND_BKT_LVL:   done_sel = done_find_i;
      S_BKT_ACROSS_BIN: done_sel = done_bkt_i;
      S_UPDATE_BIN:     done_sel = done_update_i;
      default:          done_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sat_d       = sat_q;
    unsat_d     = unsat_q;
    abt_d       = abt_q;
    err_code_d  = err_code_q;
    err_phase_d = err_phase_q;
    cur_bin_d   = cur_bin_q;
    nb_all_d    = nb_all_q;
    cur_lvl_d   = cur_lvl_q;
    iter_d      = iter_q;
    bkt_d       = bkt_q;
    from_core_d = from_core_q;
    wd_d        = wd_q;
    armed_d     = armed_q;
    start_d     = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_bm_i) begin
          state_d     = S_RD_BIN_INFO;
          sat_d       = 1'b0;
          unsat_d     = 1'b0;
          abt_d       = 1'b0;
          err_code_d  = 2'd0;
          err_phase_d = 3'd0;
          iter_d      = '0;
          bkt_d       = '0;
          cur_bin_d   = BIN_ONE;
          cur_lvl_d   = '0;
        end
      end
      default: begin
        if (abort_i) begin
          state_d    = S_DONE;
          abt_d      = 1'b1;
          err_code_d = 2'd1;
        end else if (done_ok) begin
          case (state_q)
            S_RD_BIN_INFO: begin
              nb_all_d = nb_all_i;
              if (nb_all_i == '0) begin
                state_d = S_DONE;
                sat_d   = 1'b1;
              end else begin
                state_d = S_LOAD_BIN;
              end
            end
            S_LOAD_BIN: state_d = S_RUN_CORE;
            S_RUN_CORE: begin
              if (local_sat_i && bin_is_last) begin
                state_d = S_DONE;
                sat_d   = 1'b1;
              end else if (local_sat_i) begin
                state_d     = S_UPDATE_BIN;
                cur_lvl_d   = cur_lvl_from_core_i;
                from_core_d = 1'b1;
              end else begin
                state_d = S_FIND_BKT_LVL;
              end
            end
            S_FIND_BKT_LVL: begin
              if (bkt_bin_from_find_i == '0) begin
                state_d = S_DONE;
                unsat_d = 1'b1;
              end else begin
                state_d   = S_BKT_ACROSS_BIN;
                cur_lvl_d = bkt_lvl_from_find_i;
                cur_bin_d = bkt_bin_from_find_i;
                bkt_d     = bkt_inc;
              end
            end
            S_BKT_ACROSS_BIN: begin
              state_d     = S_UPDATE_BIN;
              from_core_d = 1'b0;
            end
            S_UPDATE_BIN: begin
              if (from_core_q) cur_bin_d = cur_bin_q + BIN_ONE;
              // The iteration limit is judged on LOAD entry: a blocked load
              // never enters LOAD_BIN, so no load pulse is produced.
              if (load_blocked) begin
                state_d    = S_DONE;
                abt_d      = 1'b1;
                err_code_d = 2'd2;
              end else begin
                state_d = S_LOAD_BIN;
              end
            end
            default: state_d = state_q;
          endcase
        end else if (tmo_hit) begin
          state_d     = S_DONE;
          abt_d       = 1'b1;
          err_code_d  = 2'd3;
          err_phase_d = state_q;
        end
      end
    endcase

    // No state has a self-loop, so every entry shows up as a state change.
    enter = (state_d != state_q);

    if (enter && (state_d == S_RUN_CORE)) iter_d = iter_inc;

    // The watchdog holds the number of cycles spent in the current phase, counting its first cycle as 1.
    if (enter)                       wd_d = TMO_ONE;
    else if (in_phase && !(&wd_q))   wd_d = wd_q + TMO_ONE;

    armed_d = enter ? 1'b0 : (armed_q || (start_q != '0));

    if (enter) begin
      case (state_d)
        S_RD_BIN_INFO:    start_d[0] = 1'b1;
        S_LOAD_BIN:       start_d[1] = 1'b1;
        S_RUN_CORE:       start_d[2] = 1'b1;
        S_FIND_BKT_LVL:   start_d[3] = 1'b1;
        S_BKT_ACROSS_BIN: start_d[4] = 1'b1;
        S_UPDATE_BIN:     start_d[5] = 1'b1;
        default:          start_d    = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sat_q       <= 1'b0;
      unsat_q     <= 1'b0;
      abt_q       <= 1'b0;
      err_code_q  <= 2'd0;
      err_phase_q <= 3'd0;
      cur_bin_q   <= BIN_ONE;
      nb_all_q    <= '0;
      cur_lvl_q   <= '0;
      iter_q      <= '0;
      bkt_q       <= '0;
      wd_q        <= '0;
      from_core_q <= 1'b0;
      armed_q     <= 1'b0;
      start_q     <= '0;
    end else begin
      state_q     <= state_d;
      sat_q       <= sat_d;
      unsat_q     <= unsat_d;
      abt_q       <= abt_d;
      err_code_q  <= err_code_d;
      err_phase_q <= err_phase_d;
      cur_bin_q   <= cur_bin_d;
      nb_all_q    <= nb_all_d;
      cur_lvl_q   <= cur_lvl_d;
      iter_q      <= iter_d;
      bkt_q       <= bkt_d;
      wd_q        <= wd_d;
      from_core_q <= from_core_d;
      armed_q     <= armed_d;
      start_q     <= start_d;
    end
  end

  assign done_bm_o         = (state_q == S_DONE);
  assign global_sat_o      = sat_q;
  assign global_unsat_o    = unsat_q;
  assign global_abort_o    = abt_q;
  assign err_code_o        = err_code_q;
  assign err_phase_o       = err_phase_q;
  assign cur_bin_num_o     = cur_bin_q;
  assign request_bin_num_o = cur_bin_q;
  assign cur_lvl_o         = cur_lvl_q;
  assign iter_cnt_o        = iter_q;
  assign bkt_cnt_o         = bkt_q;
  assign start_rdinfo_o    = start_q[0];
  assign start_load_o      = start_q[1];
  assign start_core_o      = start_q[2];
  assign start_find_o      = start_q[3];
  assign start_bkt_o       = start_q[4];
  assign start_update_o    = start_q[5];

endmodule

// File: tb/tb_ctrl_bm_gen.sv
// tb/tb_ctrl_bm_gen.sv - self-checking bench for ctrl_bm_gen
module tb_ctrl_bm_gen;
  localparam int WB = 10, WC = 16, WL = 16, WT = 16, WI = 24;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_bm_i, abort_i;
  logic [WT-1:0] timeout_cfg_i;
  logic [WI-1:0] max_iter_i;
  logic          done_bm_o, global_sat_o, global_unsat_o, global_abort_o;
  logic [1:0]    err_code_o;
  logic [2:0]    err_phase_o;
  logic [WB-1:0] cur_bin_num_o, request_bin_num_o;
  logic [WL-1:0] cur_lvl_o;
  logic [WI-1:0] iter_cnt_o, bkt_cnt_o;
  logic          start_rdinfo_o, done_rdinfo_i;
  logic [WC-1:0] nb_all_i;
  logic          start_load_o, done_load_i;
  logic          start_core_o, done_core_i, local_sat_i;
  logic [WL-1:0] cur_lvl_from_core_i;
  logic          start_find_o, done_find_i;
  logic [WL-1:0] bkt_lvl_from_find_i;
  logic [WB-1:0] bkt_bin_from_find_i;
  logic          start_bkt_o, done_bkt_i, start_update_o, done_update_i;
  logic [5:0]    pv;

  ctrl_bm_gen dut (
    .clk(clk), .rst(rst), .start_bm_i(start_bm_i), .abort_i(abort_i),
    .timeout_cfg_i(timeout_cfg_i), .max_iter_i(max_iter_i),
    .done_bm_o(done_bm_o), .global_sat_o(global_sat_o), .global_unsat_o(global_unsat_o),
    .global_abort_o(global_abort_o), .err_code_o(err_code_o), .err_phase_o(err_phase_o),
    .cur_bin_num_o(cur_bin_num_o), .request_bin_num_o(request_bin_num_o), .cur_lvl_o(cur_lvl_o),
    .iter_cnt_o(iter_cnt_o), .bkt_cnt_o(bkt_cnt_o),
    .start_rdinfo_o(start_rdinfo_o), .done_rdinfo_i(done_rdinfo_i), .nb_all_i(nb_all_i),
    .start_load_o(start_load_o), .done_load_i(done_load_i),
    .start_core_o(start_core_o), .done_core_i(done_core_i), .local_sat_i(local_sat_i),
    .cur_lvl_from_core_i(cur_lvl_from_core_i),
    .start_find_o(start_find_o), .done_find_i(done_find_i),
    .bkt_lvl_from_find_i(bkt_lvl_from_find_i), .bkt_bin_from_find_i(bkt_bin_from_find_i),
    .start_bkt_o(start_bkt_o), .done_bkt_i(done_bkt_i),
    .start_update_o(start_update_o), .done_update_i(done_update_i)
  );

  always #5 clk = ~clk;

  assign pv = {start_update_o, start_bkt_o, start_find_o, start_core_o, start_load_o, start_rdinfo_o};

  typedef struct {
    int nb_all; int mask; int fbin; int flvl; int tmo; int max_iter;
    int res;  // 0 sat, 1 unsat, 2 abort
    int err; int iter; int bkt; int lvl; int upd; int bktp;
    int n_ld; int ld_bin[8]; int ld_lvl[8];
  } vec_t;

  vec_t vec[5];
  int   q_bin[$];
  int   q_lvl[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_dones();
    done_rdinfo_i = 1'b0; done_load_i = 1'b0; done_core_i = 1'b0;
    done_find_i = 1'b0; done_bkt_i = 1'b0; done_update_i = 1'b0;
  endtask

  function automatic logic pulse_sel(input int w);
    case (w)
      1: return start_rdinfo_o;
      2: return start_load_o;
      3: return start_core_o;
      4: return start_find_o;
      5: return start_bkt_o;
      6: return start_update_o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_pulse(input int w, input string nm);
    int n;
    n = 0;
    while (!pulse_sel(w) && n < 50) begin
      step();
      n++;
    end
    check(nm, 32'(pulse_sel(w)), 1);
  endtask

  task automatic set_vec(input int i, input int nb, input int mask, input int fbin, input int flvl,
                         input int tmo, input int maxi, input int res, input int err, input int iter,
                         input int bkt, input int lvl, input int upd, input int bktp);
    vec[i].nb_all = nb; vec[i].mask = mask; vec[i].fbin = fbin; vec[i].flvl = flvl;
    vec[i].tmo = tmo; vec[i].max_iter = maxi; vec[i].res = res; vec[i].err = err;
    vec[i].iter = iter; vec[i].bkt = bkt; vec[i].lvl = lvl; vec[i].upd = upd;
    vec[i].bktp = bktp; vec[i].n_ld = 0;
  endtask

  task automatic add_ld(input int i, input int b, input int l);
    vec[i].ld_bin[vec[i].n_ld] = b;
    vec[i].ld_lvl[vec[i].n_ld] = l;
    vec[i].n_ld++;
  endtask

  // Runs one table entry with a responder that answers each start pulse LAT+1 cycles later.
  task automatic run_vec(input int i);
    vec_t v;
    int pend, cnt, cidx, nupd, nbktp, eb, el;
    bit fin;
    v = vec[i];
    timeout_cfg_i = WT'(v.tmo);
    max_iter_i = WI'(v.max_iter);
    cur_lvl_from_core_i = 16'd7;
    for (int k = 0; k < v.n_ld; k++) begin
      q_bin.push_back(v.ld_bin[k]);
      q_lvl.push_back(v.ld_lvl[k]);
    end
    start_bm_i = 1'b1;
    step();
    start_bm_i = 1'b0;
    pend = 0; cnt = 0; cidx = 0; nupd = 0; nbktp = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      clr_dones();
      if (done_bm_o) begin
        fin = 1'b1;
        break;
      end
      if (start_load_o) begin
        if (q_bin.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL s%0d_extra_load actual_bin=%0d required=none", i, request_bin_num_o);
        end else begin
          eb = q_bin.pop_front();
          el = q_lvl.pop_front();
          check($sformatf("s%0d_load_bin", i), 32'(request_bin_num_o), eb);
          check($sformatf("s%0d_load_lvl", i), 32'(cur_lvl_o), el);
        end
      end
      if (start_update_o) nupd++;
      if (start_bkt_o) nbktp++;
      if (pend != 0) begin
        if (cnt == 0) begin
          case (pend)
            1: begin nb_all_i = WC'(v.nb_all); done_rdinfo_i = 1'b1; end
            2: done_load_i = 1'b1;
            3: begin local_sat_i = ((v.mask >> cidx) & 1) != 0; cidx++; done_core_i = 1'b1; end
            4: begin
              bkt_bin_from_find_i = WB'(v.fbin);
              bkt_lvl_from_find_i = WL'(v.flvl);
              done_find_i = 1'b1;
            end
            5: done_bkt_i = 1'b1;
            default: done_update_i = 1'b1;
          endcase
          pend = 0;
        end else begin
          cnt--;
        end
      end
      for (int w = 1; w <= 6; w++) begin
        if (pulse_sel(w)) begin
          pend = w;
          cnt = LAT;
        end
      end
      step();
    end
    clr_dones();
    check($sformatf("s%0d_finished", i), 32'(fin), 1);
    check($sformatf("s%0d_sat", i), 32'(global_sat_o), (v.res == 0) ? 1 : 0);
    check($sformatf("s%0d_unsat", i), 32'(global_unsat_o), (v.res == 1) ? 1 : 0);
    check($sformatf("s%0d_abort", i), 32'(global_abort_o), (v.res == 2) ? 1 : 0);
    check($sformatf("s%0d_err", i), 32'(err_code_o), v.err);
    check($sformatf("s%0d_iter", i), 32'(iter_cnt_o), v.iter);
    check($sformatf("s%0d_bkt", i), 32'(bkt_cnt_o), v.bkt);
    check($sformatf("s%0d_lvl", i), 32'(cur_lvl_o), v.lvl);
    check($sformatf("s%0d_upd_pulses", i), nupd, v.upd);
    check($sformatf("s%0d_bkt_pulses", i), nbktp, v.bktp);
    check($sformatf("s%0d_loads_left", i), q_bin.size(), 0);
    q_bin.delete();
    q_lvl.delete();
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_done"}, 32'(done_bm_o), 0);
    check({p, "_flags"}, 32'({global_sat_o, global_unsat_o, global_abort_o}), 0);
    check({p, "_err"}, 32'({err_code_o, err_phase_o}), 0);
    check({p, "_cur_bin"}, 32'(cur_bin_num_o), 1);
    check({p, "_req_bin"}, 32'(request_bin_num_o), 1);
    check({p, "_lvl"}, 32'(cur_lvl_o), 0);
    check({p, "_cnts"}, 32'(iter_cnt_o) | 32'(bkt_cnt_o), 0);
    check({p, "_pulses"}, 32'(pv), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start_bm_i = 1'b0; abort_i = 1'b0;
    timeout_cfg_i = '0; max_iter_i = '0; nb_all_i = '0;
    local_sat_i = 1'b0; cur_lvl_from_core_i = '0;
    bkt_lvl_from_find_i = '0; bkt_bin_from_find_i = '0;
    clr_dones();

    //      i  nb  mask  fbin flvl tmo max res err iter bkt lvl upd bktp
    set_vec(0, 3, 'hff, 0, 0, 0, 0, 0, 0, 3, 0, 7, 2, 0);
    add_ld(0, 1, 0); add_ld(0, 2, 7); add_ld(0, 3, 7);
    set_vec(1, 3, 'h1d, 1, 5, 50, 0, 0, 0, 5, 1, 7, 4, 1);
    add_ld(1, 1, 0); add_ld(1, 2, 7); add_ld(1, 1, 5); add_ld(1, 2, 7); add_ld(1, 3, 7);
    set_vec(2, 3, 'h00, 0, 9, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add_ld(2, 1, 0);
    set_vec(3, 3, 'h00, 1, 3, 0, 2, 2, 2, 2, 2, 3, 2, 2);
    add_ld(3, 1, 0); add_ld(3, 1, 3);
    set_vec(4, 0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_vec(i);

    // Watchdog on a load that never completes, then restart from DONE.
    timeout_cfg_i = 16'd10;
    max_iter_i = '0;
    start_bm_i = 1'b1; step(); start_bm_i = 1'b0;
    wait_pulse(1, "tmo_rd_pulse");
    step();
    nb_all_i = 16'd3; done_rdinfo_i = 1'b1; step(); clr_dones();
    wait_pulse(2, "tmo_load_pulse");
    n = 0;
    while (!done_bm_o && n < 40) begin
      step();
      n++;
    end
    check("tmo_cycles", n, 10);
    check("tmo_abort", 32'(global_abort_o), 1);
    check("tmo_err_code", 32'(err_code_o), 3);
    check("tmo_err_phase", 32'(err_phase_o), 2);
    start_bm_i = 1'b1; step(); start_bm_i = 1'b0;
    check("restart_rd_pulse", 32'(start_rdinfo_o), 1);
    check("restart_cleared", 32'({done_bm_o, global_abort_o, err_code_o, err_phase_o}), 0);
    abort_i = 1'b1; step(); abort_i = 1'b0;
    check("rd_abort_done", 32'(done_bm_o), 1);
    check("rd_abort_err", 32'(err_code_o), 1);

    // Early and stray dones in LOAD_BIN, then abort coincident with done_core.
    timeout_cfg_i = '0;
    start_bm_i = 1'b1; step(); start_bm_i = 1'b0;
    wait_pulse(1, "ab_rd_pulse");
    step();
    nb_all_i = 16'd3; done_rdinfo_i = 1'b1; step(); clr_dones();
    wait_pulse(2, "ab_load_pulse");
    done_load_i = 1'b1; done_core_i = 1'b1; step(); clr_dones();
    n = 0;
    for (int k = 0; k < 3; k++) begin
      n += $countones(pv);
      step();
    end
    check("stray_pulses", n, 0);
    check("stray_not_done", 32'(done_bm_o), 0);
    done_load_i = 1'b1; step(); clr_dones();
    wait_pulse(3, "ab_core_pulse");
    check("ab_iter", 32'(iter_cnt_o), 1);
    step();
    abort_i = 1'b1; local_sat_i = 1'b1; done_core_i = 1'b1;
    step();
    abort_i = 1'b0; clr_dones();
    check("ab_done", 32'(done_bm_o), 1);
    check("ab_err_code", 32'(err_code_o), 1);
    check("ab_flags", 32'({global_sat_o, global_unsat_o, global_abort_o}), 1);

    // Reset in the middle of RUN_CORE.
    start_bm_i = 1'b1; step(); start_bm_i = 1'b0;
    wait_pulse(1, "rs_rd_pulse");
    step();
    nb_all_i = 16'd3; done_rdinfo_i = 1'b1; step(); clr_dones();
    wait_pulse(2, "rs_load_pulse");
    step();
    done_load_i = 1'b1; step(); clr_dones();
    wait_pulse(3, "rs_core_pulse");
    step();
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    step();
    step();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      n += $countones(pv);
      step();
    end
    check("midrst_no_pulses", n, 0);
    check("midrst_idle", 32'(done_bm_o), 0);
    start_bm_i = 1'b1; step(); start_bm_i = 1'b0;
    check("midrst_restart_rd", 32'(start_rdinfo_o), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
